mem_interface: RTL and testbench

Memory-interface stage sitting directly upstream of the datapath bus multiplexer. Holds the MAR and MDR, runs single-word read/write transactions against the synchronous RAM over a req/ack handshake, and drives the MDR contents onto the bus-mux MDR input. The control unit issues one-cycle Read/Write strobes and waits on `done`.

---
 rtl/mem_interface_pkg.sv | 15 +
 rtl/mem_interface_data_reg.sv | 32 +++
 rtl/mem_interface.sv | 135 +++++++++++++
 tb/tb_mem_interface.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_interface_pkg.sv
// Shared definitions for the memory-interface stage: state encoding and the
// default bus / address widths also used by the bus and register file.
package mem_interface_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ADDR_BITS = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_interface_data_reg.sv
// Parameterised register with load enable and asynchronous active-low clear.
// Used for both MAR and MDR.
module mem_interface_data_reg
  import mem_interface_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Hold the current value unless a load is requested
  always_comb begin
    data_d = data_q;
    if (load) data_d = d;
  end

  // Storage flop, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/mem_interface.sv
// Memory-interface stage: MAR/MDR plus a single-word read/write engine
// towards the synchronous RAM. The control unit pulses Read or Write for one
// cycle in IDLE and then waits for the one-cycle done pulse.
//
// Memory handshake: mem_req is held high for the whole RD/WR state, with
// mem_we/mem_addr/mem_wdata stable alongside it; the RAM completes the word
// by raising mem_ack for one cycle, sampled on the rising edge (read data in
// mem_rdata in the same cycle). Without an ack the request is abandoned after
// TIMEOUT cycles and the transaction finishes with err during DONE.
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int wordSize = WORD_SIZE,
  parameter int addrBits = ADDR_BITS,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [wordSize-1:0] BusMuxOut,
  input  logic                MARin,
  input  logic                MDRin,
  input  logic                Read,
  input  logic                Write,
  output logic [wordSize-1:0] BusMuxIn_MDR,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [addrBits-1:0] mem_addr,
  output logic [wordSize-1:0] mem_wdata,
  input  logic [wordSize-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic [1:0]          dbg_state
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  // Last wait cycle: with no ack here the request has been up TIMEOUT cycles
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              illegal_q, illegal_d;

  logic                mar_load;
  logic                mdr_load;
  logic [wordSize-1:0] mdr_din;
  logic [addrBits-1:0] mar_val;
  logic [wordSize-1:0] mdr_val;

  // State register, wait counter and error flags
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic: strobe decode in IDLE, ack/timeout wait in RD/WR
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (Read && Write) illegal_d = 1'b1;
        else if (Read)     state_d   = RD;
        else if (Write)    state_d   = WR;
      end
      RD, WR: begin
        if (mem_ack) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    mem_req   = (state_q == RD) || (state_q == WR);
    mem_we    = (state_q == WR);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    err       = ((state_q == DONE) && timeout_q) || illegal_q;
    dbg_state = state_q;
  end

  // MAR loads only in IDLE. MDR takes the bus in IDLE unless a read is being
  // launched on the same edge (the read result then owns MDR), and takes the
  // read data when the RAM acks a read.
  assign mar_load = (state_q == IDLE) && MARin;
  assign mdr_load = ((state_q == IDLE) && MDRin && !Read) ||
                    ((state_q == RD) && mem_ack);
  assign mdr_din  = (state_q == RD) ? mem_rdata : BusMuxOut;

  mem_interface_data_reg #(.WIDTH(addrBits)) u_mar (
    .clk   (clk),
    .rst_n (clr),
    .load  (mar_load),
    .d     (BusMuxOut[addrBits-1:0]),
    .q     (mar_val)
  );

  mem_interface_data_reg #(.WIDTH(wordSize)) u_mdr (
    .clk   (clk),
    .rst_n (clr),
    .load  (mdr_load),
    .d     (mdr_din),
    .q     (mdr_val)
  );

  assign mem_addr     = mar_val;
  assign mem_wdata    = mdr_val;
  assign BusMuxIn_MDR = mdr_val;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: a vector table of directed transactions, hand
// sequences for reset mid-read and MDRin/Read collisions, then random
// transactions checked against a transaction-level model of MAR/MDR.
module tb_mem_interface;

  localparam int W = 32;
  localparam int A = 9;
  localparam int T = 15;

  logic         clk = 1'b0;
  logic         clr;
  logic [W-1:0] BusMuxOut;
  logic         MARin, MDRin, Read, Write;
  logic [W-1:0] BusMuxIn_MDR;
  logic         busy, done, err, mem_req, mem_we;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata, mem_rdata;
  logic         mem_ack;
  logic [1:0]   dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_interface #(.wordSize(W), .addrBits(A), .TIMEOUT(T)) dut (
    .clk          (clk),
    .clr          (clr),
    .BusMuxOut    (BusMuxOut),
    .MARin        (MARin),
    .MDRin        (MDRin),
    .Read         (Read),
    .Write        (Write),
    .BusMuxIn_MDR (BusMuxIn_MDR),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [A-1:0] mar_m;
  logic [W-1:0] mdr_m;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at #1 after a rising edge.
  task automatic run_load(input bit is_mar, input logic [W-1:0] bus);
    BusMuxOut = bus;
    MARin = is_mar;
    MDRin = !is_mar;
    if (is_mar) mar_m = bus[A-1:0];
    else        mdr_m = bus;
    @(posedge clk); #1;
    MARin = 1'b0;
    MDRin = 1'b0;
    chk("load_busy", W'(busy), '0);
  endtask

  task automatic run_ill(input logic [W-1:0] bus, input bit ld_mar, input bit ld_mdr,
                         output logic err_seen);
    Read = 1'b1; Write = 1'b1;
    MARin = ld_mar; MDRin = ld_mdr; BusMuxOut = bus;
    if (ld_mar) mar_m = bus[A-1:0];
    @(posedge clk); #1;
    Read = 1'b0; Write = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    err_seen = err;
    chk("ill_err_pulse", W'(err), 1);
    chk("ill_busy", W'(busy), 0);
    chk("ill_req", W'(mem_req), 0);
    @(posedge clk); #1;
    chk("ill_err_clear", W'(err), 0);
    chk("ill_req_after", W'(mem_req), 0);
    chk("ill_mdr", BusMuxIn_MDR, mdr_m);
    chk("ill_addr", W'(mem_addr), W'(mar_m));
  endtask

  // One read or write; the RAM acks after n_wait idle request cycles
  // (n_wait >= T means it never acks). During the transaction the bench keeps
  // MARin/MDRin high with random bus data, which the DUT must ignore.
  task automatic run_txn(input bit is_read, input int n_wait, input logic [W-1:0] rdata,
                         input logic [W-1:0] bus, input bit ld_mar, input bit ld_mdr,
                         output int req_cnt, output logic err_seen);
    bit           acked;
    bit           got_done;
    bit           stop;
    logic [W-1:0] wdata_exp;
    Read = is_read; Write = !is_read;
    MARin = ld_mar; MDRin = ld_mdr; BusMuxOut = bus;
    if (ld_mar) mar_m = bus[A-1:0];
    if (ld_mdr && !is_read) mdr_m = bus;
    wdata_exp = mdr_m;
    acked = (n_wait < T);
    if (is_read && acked) mdr_m = rdata;
    exp_q.push_back(mdr_m);
    @(posedge clk); #1;
    Read = 1'b0; Write = 1'b0; MARin = 1'b1; MDRin = 1'b1;
    req_cnt = 0; err_seen = 1'b0; got_done = 1'b0; stop = 1'b0;
    for (int c = 0; c < T + 4 && !stop; c++) begin
      BusMuxOut = $urandom;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          chk("txn_we", W'(mem_we), W'(!is_read));
          chk("txn_busy", W'(busy), 1);
        end
        chk("txn_addr", W'(mem_addr), W'(mar_m));
        if (!is_read) chk("txn_wdata", mem_wdata, wdata_exp);
        mem_ack   = (req_cnt - 1 == n_wait);
        mem_rdata = mem_ack ? rdata : W'($urandom);
      end else if (done) begin
        err_seen = err;
        got_done = 1'b1;
        stop = 1'b1;
        mem_ack = 1'b0; MARin = 1'b0; MDRin = 1'b0;
      end else begin
        stop = 1'b1;
        mem_ack = 1'b0; MARin = 1'b0; MDRin = 1'b0;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    chk("txn_done_seen", W'(got_done), 1);
    chk("txn_req_cycles", W'(req_cnt), acked ? W'(n_wait + 1) : W'(T));
    chk("txn_err", W'(err_seen), W'(!acked));
    chk("txn_done_one_cycle", W'(done), 0);
    chk("txn_idle_busy", W'(busy), 0);
    chk("txn_err_clear", W'(err), 0);
    chk("txn_mdr", BusMuxIn_MDR, exp_q.pop_front());
  endtask

  // ---------------- vector table ----------------
  typedef enum int {OP_MAR, OP_MDR, OP_RD, OP_WR, OP_ILL} op_e;
  typedef struct {
    op_e          op;
    logic [W-1:0] bus;
    int           n_wait;
    logic [W-1:0] rdata;
    logic [W-1:0] exp_mdr;
    logic [A-1:0] exp_addr;
    int           exp_req;
    logic         exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int           rq;
    logic         er;
    logic [A-1:0] addr_keep;

    vecs[0] = '{OP_MAR, 32'h0000_01A5, 0,  32'h0,         32'h0000_0000, 9'h1A5, 0,  1'b0};
    vecs[1] = '{OP_RD,  32'h0,         0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 9'h1A5, 1,  1'b0};
    vecs[2] = '{OP_MDR, 32'h1234_5678, 0,  32'h0,         32'h1234_5678, 9'h1A5, 0,  1'b0};
    vecs[3] = '{OP_WR,  32'h0,         3,  32'h0,         32'h1234_5678, 9'h1A5, 4,  1'b0};
    vecs[4] = '{OP_RD,  32'h0,         99, 32'h0,         32'h1234_5678, 9'h1A5, 15, 1'b1};
    vecs[5] = '{OP_ILL, 32'h0,         0,  32'h0,         32'h1234_5678, 9'h1A5, 0,  1'b1};
    vecs[6] = '{OP_MAR, 32'hFFFF_FE00, 0,  32'h0,         32'h1234_5678, 9'h000, 0,  1'b0};
    vecs[7] = '{OP_RD,  32'h0,         14, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 9'h000, 15, 1'b0};
    vecs[8] = '{OP_WR,  32'h0,         0,  32'h0,         32'hA5A5_A5A5, 9'h000, 1,  1'b0};

    clr = 1'b0; BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0;
    Read = 1'b0; Write = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    mar_m = '0; mdr_m = '0;

    // reset state
    #12;
    chk("rst_busy", W'(busy), 0);
    chk("rst_req", W'(mem_req), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_err", W'(err), 0);
    chk("rst_mdr", BusMuxIn_MDR, 0);
    chk("rst_addr", W'(mem_addr), 0);
    clr = 1'b1;
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < 9; i++) begin
      rq = 0; er = 1'b0;
      case (vecs[i].op)
        OP_MAR: run_load(1'b1, vecs[i].bus);
        OP_MDR: run_load(1'b0, vecs[i].bus);
        OP_RD:  run_txn(1'b1, vecs[i].n_wait, vecs[i].rdata, vecs[i].bus, 1'b0, 1'b0, rq, er);
        OP_WR:  run_txn(1'b0, vecs[i].n_wait, vecs[i].rdata, vecs[i].bus, 1'b0, 1'b0, rq, er);
        default: run_ill(vecs[i].bus, 1'b0, 1'b0, er);
      endcase
      chk($sformatf("vec%0d_mdr", i), BusMuxIn_MDR, vecs[i].exp_mdr);
      chk($sformatf("vec%0d_addr", i), W'(mem_addr), W'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_req", i), W'(rq), W'(vecs[i].exp_req));
      chk($sformatf("vec%0d_err", i), W'(er), W'(vecs[i].exp_err));
    end

    // MDRin and Read on the same edge: read data wins; MARin during RD ignored
    addr_keep = mar_m;
    run_txn(1'b1, 1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b1, rq, er);
    chk("collide_mdr", BusMuxIn_MDR, 32'h0000_0005);
    chk("collide_addr", W'(mem_addr), W'(addr_keep));

    // random transactions against the model
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 3)
        run_txn(1'b1, $urandom_range(0, T + 2), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rq, er);
      else if (sel <= 6)
        run_txn(1'b0, $urandom_range(0, T + 2), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rq, er);
      else if (sel == 7)
        run_ill($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), er);
      else
        run_load(sel == 8, $urandom);
      chk("rand_addr", W'(mem_addr), W'(mar_m));
      chk("rand_mdr", BusMuxIn_MDR, mdr_m);
    end

    // reset in the middle of a read
    run_load(1'b1, 32'h0000_01FF);
    Read = 1'b1;
    @(posedge clk); #1;
    Read = 1'b0;
    chk("rstmid_req_before", W'(mem_req), 1);
    #2 clr = 1'b0;
    #1;
    chk("rstmid_req", W'(mem_req), 0);
    chk("rstmid_busy", W'(busy), 0);
    chk("rstmid_mdr", BusMuxIn_MDR, 0);
    chk("rstmid_addr", W'(mem_addr), 0);
    mar_m = '0; mdr_m = '0;
    @(posedge clk); #2;
    clr = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_idle_busy", W'(busy), 0);
    chk("rstmid_idle_req", W'(mem_req), 0);
    chk("rstmid_state", W'(dbg_state), 0);

    // a normal read after the reset still works
    run_txn(1'b1, 2, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, rq, er);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard stop if the sequence above ever stalls
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
